// File: rtl/cache_sim_pkg.sv
// -----------------------------------------------------------------------------
// cache_sim_pkg
// Shared definitions for the cache simulation slice: arbiter FSM encodings,
// the two-phase cache protocol constants and the requester identifiers.
// The protocol constants are also used by the trace benches that drive
// the cache directly.
// Ports: none (package).
// -----------------------------------------------------------------------------
package cache_sim_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      SEARCH  = 2'd2
   } arb_state_e;

   localparam logic CACHE_PRESENT = 1'b0;
   localparam logic CACHE_SEARCH  = 1'b1;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage : cache_sim_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic, purely combinational. The parent keeps
// last_grant in a register and updates it on every accept.
// Ports:
//   valid0, valid1  in   request pending from requester 0 / 1
//   last_grant      in   id of the requester granted most recently
//   grant0, grant1  out  one-hot grant (both 0 when nothing is pending)
//   grant_id        out  id of the granted requester (REQ0 when idle)
// -----------------------------------------------------------------------------
module rr_arb2
   import cache_sim_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant0,
   output logic grant1,
   output logic grant_id
);

   // A lone requester always wins. On a tie the requester that was not
   // served last gets the grant, which gives strict alternation under
   // sustained contention.
   always_comb begin
      grant0   = valid0 && (!valid1 || (last_grant == REQ1));
      grant1   = valid1 && (!valid0 || (last_grant == REQ0));
      grant_id = grant1 ? REQ1 : REQ0;
   end

endmodule : rr_arb2

// File: rtl/cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// cache_req_arbiter
// Shares one cache instance between two reference requesters and sequences
// the cache's two-phase protocol: present the address (state=0), then
// search (state=1) and capture hit. Each accepted reference produces one
// response pulse to the requester that issued it, three cycles after accept.
//
// Optional statistics: define CACHE_ARB_STATS_EN to build saturating
// per-requester reference/hit counters. Without it the counter outputs are
// tied to zero and the port list is unchanged.
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   req0_valid/addr/ready    requester 0 request handshake (ready is comb.)
//   resp0_valid/hit          requester 0 response pulse and hit result
//   req1_*, resp1_*          same for requester 1
//   cache_addr, cache_state  to cache addr_in / state (0 present, 1 search)
//   cache_hit                from cache, sampled at the end of SEARCH
//   busy                     high whenever the FSM is not in IDLE
//   refs0/hits0/refs1/hits1  statistics counters
// -----------------------------------------------------------------------------
module cache_req_arbiter
   import cache_sim_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   output logic              req0_ready,
   output logic              resp0_valid,
   output logic              resp0_hit,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              req1_ready,
   output logic              resp1_valid,
   output logic              resp1_hit,
   output logic [ADDR_W-1:0] cache_addr,
   output logic              cache_state,
   input  logic              cache_hit,
   output logic              busy,
   output logic [CNT_W-1:0]  refs0,
   output logic [CNT_W-1:0]  hits0,
   output logic [CNT_W-1:0]  refs1,
   output logic [CNT_W-1:0]  hits1
);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              resp0_valid_q, resp0_valid_d;
   logic              resp0_hit_q, resp0_hit_d;
   logic              resp1_valid_q, resp1_valid_d;
   logic              resp1_hit_q, resp1_hit_d;

   logic              arb_grant0;
   logic              arb_grant1;
   logic              arb_grant_id;

   rr_arb2 u_rr_arb2 (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant_q),
      .grant0     (arb_grant0),
      .grant1     (arb_grant1),
      .grant_id   (arb_grant_id)
   );

   // Next-state and handshake logic. Ready is only ever raised in IDLE, so a
   // request arriving while a reference is in flight simply waits. The
   // response valids default low so they pulse for exactly one cycle, while
   // the hit flags hold so the non-owner's last result stays visible.
   always_comb begin
      state_d       = state_q;
      cache_addr_d  = cache_addr_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      resp0_valid_d = 1'b0;
      resp0_hit_d   = resp0_hit_q;
      resp1_valid_d = 1'b0;
      resp1_hit_d   = resp1_hit_q;
      req0_ready    = 1'b0;
      req1_ready    = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_grant0 || arb_grant1) begin
               req0_ready   = arb_grant0;
               req1_ready   = arb_grant1;
               cache_addr_d = (arb_grant_id == REQ1) ? req1_addr : req0_addr;
               owner_d      = arb_grant_id;
               last_grant_d = arb_grant_id;
               state_d      = PRESENT;
            end
         end
         PRESENT: begin
            state_d = SEARCH;
         end
         SEARCH: begin
            if (owner_q == REQ1) begin
               resp1_valid_d = 1'b1;
               resp1_hit_d   = cache_hit;
            end else begin
               resp0_valid_d = 1'b1;
               resp0_hit_d   = cache_hit;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. Reset abandons any reference in flight without a
   // response; last_grant resets to REQ1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cache_addr_q  <= '0;
         owner_q       <= REQ0;
         last_grant_q  <= REQ1;
         resp0_valid_q <= 1'b0;
         resp0_hit_q   <= 1'b0;
         resp1_valid_q <= 1'b0;
         resp1_hit_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cache_addr_q  <= cache_addr_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         resp0_valid_q <= resp0_valid_d;
         resp0_hit_q   <= resp0_hit_d;
         resp1_valid_q <= resp1_valid_d;
         resp1_hit_q   <= resp1_hit_d;
      end
   end

   assign cache_addr  = cache_addr_q;
   assign cache_state = (state_q == SEARCH) ? CACHE_SEARCH : CACHE_PRESENT;
   assign busy        = (state_q != IDLE);
   assign resp0_valid = resp0_valid_q;
   assign resp0_hit   = resp0_hit_q;
   assign resp1_valid = resp1_valid_q;
   assign resp1_hit   = resp1_hit_q;

`ifdef CACHE_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] refs0_q, refs0_d;
   logic [CNT_W-1:0] hits0_q, hits0_d;
   logic [CNT_W-1:0] refs1_q, refs1_d;
   logic [CNT_W-1:0] hits1_q, hits1_d;

   // Statistics update. A reference is counted in the cycle it is accepted;
   // a hit is counted on the edge that registers the hit response. All
   // counters stick at their maximum instead of wrapping.
   always_comb begin
      refs0_d = refs0_q;
      hits0_d = hits0_q;
      refs1_d = refs1_q;
      hits1_d = hits1_q;

      if ((state_q == IDLE) && arb_grant0 && (refs0_q != CNT_MAX)) begin
         refs0_d = refs0_q + CNT_ONE;
      end
      if ((state_q == IDLE) && arb_grant1 && (refs1_q != CNT_MAX)) begin
         refs1_d = refs1_q + CNT_ONE;
      end
      if ((state_q == SEARCH) && cache_hit) begin
         if ((owner_q == REQ0) && (hits0_q != CNT_MAX)) begin
            hits0_d = hits0_q + CNT_ONE;
         end
         if ((owner_q == REQ1) && (hits1_q != CNT_MAX)) begin
            hits1_d = hits1_q + CNT_ONE;
         end
      end
   end

   // Statistics registers, cleared by reset together with the FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         refs0_q <= '0;
         hits0_q <= '0;
         refs1_q <= '0;
         hits1_q <= '0;
      end else begin
         refs0_q <= refs0_d;
         hits0_q <= hits0_d;
         refs1_q <= refs1_d;
         hits1_q <= hits1_d;
      end
   end

   assign refs0 = refs0_q;
   assign hits0 = hits0_q;
   assign refs1 = refs1_q;
   assign hits1 = hits1_q;
`else
   assign refs0 = '0;
   assign hits0 = '0;
   assign refs1 = '0;
   assign hits1 = '0;
`endif

endmodule : cache_req_arbiter

// File: tb/tb_cache_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_req_arbiter
// Drives two requesters against cache_req_arbiter with a stub cache that
// reports a hit for any address it has already searched. A monitor compares
// the DUT against a transaction-level model every cycle and pops expected
// responses from a scoreboard queue. Builds with or without
// CACHE_ARB_STATS_EN; the expected counter values follow the macro.
// -----------------------------------------------------------------------------
module tb_cache_req_arbiter;

   localparam int ADDR_W  = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef CACHE_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              req0_valid, req1_valid;
   logic [ADDR_W-1:0] req0_addr, req1_addr;
   logic              req0_ready, req1_ready;
   logic              resp0_valid, resp0_hit, resp1_valid, resp1_hit;
   logic [ADDR_W-1:0] cache_addr;
   logic              cache_state;
   logic              cache_hit;
   logic              busy;
   logic [CNT_W-1:0]  refs0, hits0, refs1, hits1;

   cache_req_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_addr   (req0_addr),
      .req0_ready  (req0_ready),
      .resp0_valid (resp0_valid),
      .resp0_hit   (resp0_hit),
      .req1_valid  (req1_valid),
      .req1_addr   (req1_addr),
      .req1_ready  (req1_ready),
      .resp1_valid (resp1_valid),
      .resp1_hit   (resp1_hit),
      .cache_addr  (cache_addr),
      .cache_state (cache_state),
      .cache_hit   (cache_hit),
      .busy        (busy),
      .refs0       (refs0),
      .hits0       (hits0),
      .refs1       (refs1),
      .hits1       (hits1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic              id;
      logic [ADDR_W-1:0] addr;
      logic              hit;
      int                acc;
   } exp_t;

   typedef struct {
      logic id;
      int   acc;
   } grant_t;

   exp_t              sb_q[$];
   grant_t            grant_log[$];
   int                m_last_acc;
   logic              m_lg;
   logic [ADDR_W-1:0] m_addr;
   int                m_refs[2];
   int                m_hits[2];
   logic              m_last_hit[2];
   bit                m_res[logic [ADDR_W-1:0]];
   bit                stub_res[logic [ADDR_W-1:0]];

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   function automatic int satInc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   task automatic modelReset();
      sb_q.delete();
      m_res.delete();
      m_last_acc    = -100;
      m_lg          = 1'b1;
      m_addr        = '0;
      m_refs[0]     = 0;
      m_refs[1]     = 0;
      m_hits[0]     = 0;
      m_hits[1]     = 0;
      m_last_hit[0] = 1'b0;
      m_last_hit[1] = 1'b0;
   endtask

   // Stub cache: an address becomes resident once it has been searched.
   // Outside SEARCH the hit line carries random noise the DUT must ignore.
   always @(posedge clk) begin
      if (reset) stub_res.delete();
      else if (cache_state) stub_res[cache_addr] = 1'b1;
   end

   initial cache_hit = 1'b0;
   always @(negedge clk) begin
      if (cache_state) cache_hit = (stub_res.exists(cache_addr) != 0);
      else             cache_hit = 1'($urandom_range(0, 1));
   end

   // Monitor: a reference occupies the cache for three cycles after its
   // accept; arbitration is "lone requester wins, ties alternate".
   initial begin
      logic g0, g1, free, rv, rh, gid;
      logic [ADDR_W-1:0] a;
      exp_t e;
      modelReset();
      forever begin
         @(negedge clk);
         if (reset) begin
            modelReset();
         end else begin
            for (int id = 0; id < 2; id++) begin
               rv = (id == 0) ? resp0_valid : resp1_valid;
               rh = (id == 0) ? resp0_hit : resp1_hit;
               if (rv) begin
                  if (sb_q.size() == 0) begin
                     checkOutput("resp_unexpected_valid", 64'(rv), 64'd0);
                  end else begin
                     e = sb_q.pop_front();
                     checkOutput("resp_owner", 64'(id), 64'(e.id));
                     checkOutput("resp_hit", 64'(rh), 64'(e.hit));
                     checkOutput("resp_latency", 64'(cyc), 64'(e.acc + 3));
                     m_last_hit[e.id] = e.hit;
                     if (e.hit) m_hits[e.id] = satInc(m_hits[e.id]);
                  end
               end
            end
            if (sb_q.size() > 0 && cyc >= sb_q[0].acc + 3) begin
               checkOutput("resp_missing", 64'd0, 64'd1);
               void'(sb_q.pop_front());
            end

            checkOutput("resp0_hit_hold", 64'(resp0_hit), 64'(m_last_hit[0]));
            checkOutput("resp1_hit_hold", 64'(resp1_hit), 64'(m_last_hit[1]));
            checkOutput("busy", 64'(busy),
                        64'((cyc == m_last_acc + 1) || (cyc == m_last_acc + 2)));
            checkOutput("cache_state", 64'(cache_state), 64'(cyc == m_last_acc + 2));
            checkOutput("cache_addr", 64'(cache_addr), 64'(m_addr));
            checkOutput("refs0", 64'(refs0), STATS ? 64'(m_refs[0]) : 64'd0);
            checkOutput("hits0", 64'(hits0), STATS ? 64'(m_hits[0]) : 64'd0);
            checkOutput("refs1", 64'(refs1), STATS ? 64'(m_refs[1]) : 64'd0);
            checkOutput("hits1", 64'(hits1), STATS ? 64'(m_hits[1]) : 64'd0);

            free = (cyc >= m_last_acc + 3);
            g0   = free && req0_valid && (!req1_valid || m_lg == 1'b1);
            g1   = free && req1_valid && (!req0_valid || m_lg == 1'b0);
            checkOutput("req0_ready", 64'(req0_ready), 64'(g0));
            checkOutput("req1_ready", 64'(req1_ready), 64'(g1));
            if (g0 || g1) begin
               gid = g1;
               a   = gid ? req1_addr : req0_addr;
               e.id   = gid;
               e.addr = a;
               e.hit  = (m_res.exists(a) != 0);
               e.acc  = cyc;
               sb_q.push_back(e);
               m_res[a] = 1'b1;
               grant_log.push_back('{id: gid, acc: cyc});
               m_last_acc  = cyc;
               m_lg        = gid;
               m_addr      = a;
               m_refs[gid] = satInc(m_refs[gid]);
            end
         end
      end
   end

   // Raise a request, hold it until it is accepted, then drop it.
   task automatic applyStimulus(input int id, input logic [ADDR_W-1:0] addr);
      int  waited = 0;
      bit  done   = 1'b0;
      if (id == 0) begin req0_valid = 1'b1; req0_addr = addr; end
      else         begin req1_valid = 1'b1; req1_addr = addr; end
      while (!done) begin
         @(negedge clk);
         if (((id == 0) ? req0_ready : req1_ready) && !reset) begin
            done = 1'b1;
         end else begin
            waited++;
            if (waited > 200) begin
               checkOutput("req_accept_timeout", 64'(waited), 64'd200);
               done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
   endtask

   task automatic runRequester(input int id, input int count, input int gap_max,
                               input logic [ADDR_W-1:0] base);
      int gap;
      for (int i = 0; i < count; i++) begin
         gap = $urandom_range(0, gap_max);
         repeat (gap) begin @(posedge clk); #1; end
         applyStimulus(id, base + (ADDR_W'($urandom_range(0, 7)) << 4));
      end
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic waitDrain();
      int k = 0;
      while (sb_q.size() > 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      repeat (2) @(posedge clk);
      #1;
      checkOutput("drain_pending", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_addr  = '0;
      req1_addr  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] reset state");
      @(negedge clk);
      checkOutput("rst_cache_addr", 64'(cache_addr), 64'd0);
      checkOutput("rst_cache_state", 64'(cache_state), 64'd0);
      checkOutput("rst_resp_valid", 64'({resp0_valid, resp1_valid}), 64'd0);
      checkOutput("rst_resp_hit", 64'({resp0_hit, resp1_hit}), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_stats", 64'({refs0, hits0, refs1, hits1}), 64'd0);
      @(posedge clk); #1;

      $display("[TB] single request then repeat");
      applyStimulus(0, 32'h0000_1000);
      waitDrain();
      applyStimulus(0, 32'h0000_1000);
      waitDrain();
      @(negedge clk);
      checkOutput("repeat_refs0", 64'(refs0), STATS ? 64'd2 : 64'd0);
      checkOutput("repeat_hits0", 64'(hits0), STATS ? 64'd1 : 64'd0);
      checkOutput("repeat_last_hit0", 64'(resp0_hit), 64'd1);
      @(posedge clk); #1;

      $display("[TB] reset during SEARCH");
      applyStimulus(1, 32'h0000_2000);
      @(posedge clk); #1;
      checkOutput("midrst_in_search", 64'(cache_state), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midrst_resp1_valid", 64'(resp1_valid), 64'd0);
      checkOutput("midrst_cache_addr", 64'(cache_addr), 64'd0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_stats", 64'({refs0, hits0, refs1, hits1}), 64'd0);
      @(posedge clk); #1;

      $display("[TB] contention");
      grant_log.delete();
      fork
         runRequester(0, 4, 0, 32'h0000_4000);
         runRequester(1, 4, 0, 32'h0000_4000);
      join
      waitDrain();
      checkOutput("contention_grants", 64'(grant_log.size()), 64'd8);
      for (int i = 0; i < grant_log.size(); i++) begin
         checkOutput("contention_order", 64'(grant_log[i].id), 64'(i % 2));
         if (i > 0) begin
            checkOutput("contention_spacing",
                        64'(grant_log[i].acc - grant_log[i-1].acc), 64'd3);
         end
      end

      $display("[TB] random traffic");
      fork
         runRequester(0, 30, 4, 32'h0000_8000);
         runRequester(1, 30, 4, 32'h0000_8000);
      join
      waitDrain();

      $display("[TB] saturation");
      doReset();
      for (int i = 0; i < 18; i++) begin
         applyStimulus(0, 32'h0000_ABC0);
      end
      waitDrain();
      @(negedge clk);
      checkOutput("sat_hits0", 64'(hits0), STATS ? 64'(CNT_MAX) : 64'd0);
      checkOutput("sat_refs0", 64'(refs0), STATS ? 64'(CNT_MAX) : 64'd0);
      checkOutput("sat_last_hit0", 64'(resp0_hit), 64'd1);
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_cache_req_arbiter

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Shares the single `cache` instance between two reference requesters, e.g. an instruction stream and a data stream replayed from separate trace ROMs.
- Owns the cache's two-phase protocol. It drives `state`=0 to present an address, then `state`=1 to search, and samples `hit` at the end of the search cycle.
- Returns one hit/miss response per accepted reference to the requester that issued it.
- Sits between the trace sources and `cache`, replacing the hand-sequenced state toggle.

Parameters:
- ADDR_W, 32, width of reference addresses and of cache_addr.
- CNT_W, 16, width of the per-requester statistic counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a reference pending.
- req0_addr  in  ADDR_W  requester 0 reference address; sampled on accept.
- req0_ready  out  1  combinational; high in the cycle the requester 0 reference is accepted.
- resp0_valid  out  1  one-cycle pulse; the requester 0 result is valid.
- resp0_hit  out  1  hit result for requester 0; meaningful only when resp0_valid=1.
- req1_valid, req1_addr, req1_ready, resp1_valid, resp1_hit: same as the requester 0 ports, for requester 1.
- cache_addr  out  ADDR_W  to cache addr_in.
- cache_state  out  1  to cache state; 0 = present, 1 = search.
- cache_hit  in  1  from cache hit; valid during the search cycle.
- busy  out  1  high whenever the FSM is not in IDLE.
- refs0, hits0, refs1, hits1  out  CNT_W each  statistics counters (see Optional Feature).

Behaviour:
- Reset values: FSM=IDLE; cache_addr=0; cache_state=0; all resp*_valid=0; all resp*_hit=0; busy=0; last_grant=1 (so requester 0 wins the first tie); counters=0.
- FSM states:
  - IDLE: if any reqN_valid, grant one requester. reqN_ready=1 for the granted requester only. Latch its address into cache_addr and the requester id into owner. Next state = PRESENT. With no valid request, remain in IDLE.
  - PRESENT: cache_state=0; cache_addr held. Next state = SEARCH unconditionally.
  - SEARCH: cache_state=1; cache_addr held. At the clock edge, register resp_hit=cache_hit for owner, pulse resp_valid for owner, and go to IDLE.
- ready is only ever asserted in IDLE; it is never high in PRESENT or SEARCH.
- cache_state=0 in IDLE and PRESENT; 1 only in SEARCH. cache_addr changes only on accept.
- Latency: accept in cycle T → present in T+1 → search in T+2 → respN_valid=1 in T+3.
  - T+3 is an IDLE cycle, so a new accept may coincide with the response pulse.
  - Sustained throughput is one reference per 3 cycles.
- Arbitration:
  - Single valid requester wins regardless of last_grant.
  - Both valid: grant the requester ≠ last_grant. last_grant updates on every accept.
- A requester must hold reqN_valid and reqN_addr stable until it sees reqN_ready. The arbiter never drops a pending request.
- resp_hit for the non-owner holds its previous value; its resp_valid stays 0.
- reset asserted mid-operation (PRESENT or SEARCH): the reference is abandoned, no response pulse is produced, and all registers return to reset values at that edge.
- cache_hit is ignored outside SEARCH.

Optional Feature:
- Macro: CACHE_ARB_STATS_EN.
- Defined: refsN increments on each accept for requester N; hitsN increments when that requester's response carries hit=1. Both counters saturate at 2^CNT_W−1 and never wrap.
- Undefined: the counter logic is not built; refs0/hits0/refs1/hits1 are tied to 0. The port list is unchanged, so instantiations stay identical.

Decomposition:
- Shared package cache_sim_pkg:
  - FSM state encodings: IDLE, PRESENT, SEARCH.
  - CACHE_PRESENT=1'b0 and CACHE_SEARCH=1'b1 constants, also used by the trace benches.
  - Requester id constants REQ0=0, REQ1=1.
- Sub-module rr_arb2: 2-way round-robin grant logic.
  - Inputs: valid0, valid1, last_grant.
  - Outputs: grant0, grant1, grant_id.
  - Purely combinational; last_grant is registered in the parent.

Test Plan:
- Single request: reset, then req0 addr=0x0000_1000 with a stub cache returning hit=0. Required: cache_state sequence 0,0,1 over cycles T..T+2; resp0_valid=1 only at T+3 with resp0_hit=0; resp1_valid never asserted.
- Repeat and hit: req0 0x1000 twice, stub hits on the second search. Required: responses at T+3 and T+6 with hit 0 then 1; with the macro defined, refs0=2 and hits0=1.
- Contention: req0 and req1 both held valid for 4 references each. Required: grants strictly alternate 0,1,0,1,…; accepts spaced exactly 3 cycles; each response goes to the correct requester with the correct address seen on cache_addr.
- Reset mid-op: accept req1 0x2000, then assert reset during SEARCH. Required: no resp1_valid pulse; cache_addr=0, busy=0 and counters=0 after the reset edge.
- Saturation (macro on, CNT_W=4): 17 hits on req0. Required: hits0 stops at 15 and never wraps.
- Macro off: the same stimulus as the saturation test. Required: all stats outputs stay 0; responses are identical to the macro-on run.
